// File: rtl/xor_stream_cipher.sv
//----------------------------------------------------------------------------
// xor_stream_cipher
//
// Purpose:
//   Streaming XOR cipher with a single registered output stage. Each accepted
//   beat is XORed with a key word chosen by 'mode' at the moment of
//   acceptance:
//     00 : bypass (key = 0)
//     01 : static key (key bank entry 0)
//     10 : rotating key bank (entry idx, idx advances once per accepted beat)
//     11 : 16-bit Fibonacci LFSR keystream (low DATA_W bits of the LFSR)
//   Because encryption and decryption are the same XOR, the block serves both
//   directions.
//
// Ports:
//   clk          in   1          rising-edge clock
//   rst          in   1          synchronous active-high reset
//   mode         in   2          key source select
//   key_wr_en    in   1          key bank write strobe
//   key_wr_addr  in   KA_W       key bank write address
//   key_wr_data  in   DATA_W     key bank write data
//   lfsr_seed    in   16         LFSR seed, loaded on restart (0 -> 16'hACE1)
//   restart      in   1          rewind bank index and reload LFSR
//   in_valid     in   1          data_in valid
//   in_ready     out  1          block accepts data_in this cycle
//   data_in      in   DATA_W     input beat
//   out_valid    out  1          data_out valid
//   out_ready    in   1          downstream accepts data_out
//   data_out     out  DATA_W     registered result
//----------------------------------------------------------------------------
module xor_stream_cipher #(
    parameter  int DATA_W    = 8,
    parameter  int KEY_DEPTH = 4,
    localparam int KA_W      = $clog2(KEY_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              key_wr_en,
    input  logic [KA_W-1:0]   key_wr_addr,
    input  logic [DATA_W-1:0] key_wr_data,
    input  logic [15:0]       lfsr_seed,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out
);

    localparam logic [1:0]  MODE_BYPASS = 2'b00;
    localparam logic [1:0]  MODE_STATIC = 2'b01;
    localparam logic [1:0]  MODE_ROTATE = 2'b10;
    localparam logic [1:0]  MODE_LFSR   = 2'b11;

    // A zero seed would lock the LFSR at zero forever, so it is replaced.
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    // One step of x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    logic [DATA_W-1:0] bank_r [KEY_DEPTH];
    logic [KA_W-1:0]   idx_r;
    logic [15:0]       lfsr_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] data_out_r;

    logic              in_ready_s;
    logic              accept_s;
    logic [15:0]       seed_eff_s;
    logic [KA_W-1:0]   idx_cur_s;
    logic [15:0]       lfsr_cur_s;
    logic [DATA_W-1:0] key_s;
    logic [KA_W-1:0]   idx_next_s;
    logic [15:0]       lfsr_next_s;

    // Handshake: the single output register can take a new beat when it is
    // empty or is being drained in this same cycle.
    always_comb begin
        in_ready_s = !out_valid_r || out_ready;
        accept_s   = in_valid && in_ready_s;
    end

    // Key-sequence view for this cycle: restart rewinds the index and reloads
    // the LFSR so that a beat accepted alongside restart already uses them.
    always_comb begin
        if (lfsr_seed == 16'h0000) begin
            seed_eff_s = LFSR_DEFAULT;
        end else begin
            seed_eff_s = lfsr_seed;
        end
        if (restart) begin
            idx_cur_s  = {KA_W{1'b0}};
            lfsr_cur_s = seed_eff_s;
        end else begin
            idx_cur_s  = idx_r;
            lfsr_cur_s = lfsr_r;
        end
    end

    // Key select; bank reads see the pre-write contents on a same-cycle write.
    always_comb begin
        key_s = {DATA_W{1'b0}};
        case (mode)
            MODE_BYPASS: key_s = {DATA_W{1'b0}};
            MODE_STATIC: key_s = bank_r[0];
            MODE_ROTATE: key_s = bank_r[idx_cur_s];
            MODE_LFSR:   key_s = lfsr_cur_s[DATA_W-1:0];
            default:     key_s = {DATA_W{1'b0}};
        endcase
    end

    // Sequence advance: only the active key source moves, and only on an
    // accepted beat; the other one keeps its position across mode changes.
    always_comb begin
        idx_next_s  = idx_cur_s;
        lfsr_next_s = lfsr_cur_s;
        if (accept_s && (mode == MODE_ROTATE)) begin
            // KEY_DEPTH is a power of two, so natural overflow is the wrap.
            idx_next_s = idx_cur_s + KA_W'(1);
        end else begin
            idx_next_s = idx_cur_s;
        end
        if (accept_s && (mode == MODE_LFSR)) begin
            lfsr_next_s = lfsr_step(lfsr_cur_s);
        end else begin
            lfsr_next_s = lfsr_cur_s;
        end
    end

    // Key bank storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KEY_DEPTH; i++) begin
                bank_r[i] <= {DATA_W{1'b0}};
            end
        end else if (key_wr_en) begin
            bank_r[key_wr_addr] <= key_wr_data;
        end else begin
            bank_r <= bank_r;
        end
    end

    // Key sequence state (bank index and LFSR).
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r  <= {KA_W{1'b0}};
            lfsr_r <= LFSR_DEFAULT;
        end else begin
            idx_r  <= idx_next_s;
            lfsr_r <= lfsr_next_s;
        end
    end

    // Output register: load on accept, empty on a drain with no new beat,
    // otherwise hold (this also keeps data stable under backpressure).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            data_out_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            data_out_r  <= data_in ^ key_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            data_out_r  <= data_out_r;
        end else begin
            out_valid_r <= out_valid_r;
            data_out_r  <= data_out_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;

endmodule

// File: doc/xor_stream_cipher.md
XOR_STREAM_CIPHER -- requirements
Module: xor_stream_cipher

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data and key word width; legal range 1..16.
REQ-002 SHALL have parameter KEY_DEPTH, default 4: key bank entries; power of two, 2..16; KA_W = log2(KEY_DEPTH).
REQ-003 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port mode  input  2: 00 bypass, 01 static key, 10 rotating key bank, 11 LFSR keystream.
REQ-006 SHALL have port key_wr_en  input  1: key bank write strobe.
REQ-007 SHALL have port key_wr_addr  input  KA_W: key bank write address.
REQ-008 SHALL have port key_wr_data  input  DATA_W: key bank write data.
REQ-009 SHALL have port lfsr_seed  input  16: LFSR seed, sampled on restart.
REQ-010 SHALL have port restart  input  1: rewind key index and reload LFSR.
REQ-011 SHALL have port in_valid  input  1: data_in is valid.
REQ-012 SHALL have port in_ready  output  1: block accepts data_in this cycle.
REQ-013 SHALL have port data_in  input  DATA_W: plaintext/ciphertext beat.
REQ-014 SHALL have port out_valid  output  1: data_out is valid.
REQ-015 SHALL have port out_ready  input  1: downstream accepts data_out.
REQ-016 SHALL have port data_out  output  DATA_W: registered result.

Function
REQ-017 SHALL accept a beat when in_valid && in_ready; out transfer when out_valid && out_ready.
REQ-018 SHALL drive in_ready = !out_valid || out_ready (single output register, combinational ready path).
REQ-019 SHALL present an accepted beat on data_out with out_valid high exactly one cycle after acceptance.
REQ-020 SHALL hold data_out and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on an out transfer with no simultaneous acceptance; acceptance plus out transfer in the same cycle SHALL keep out_valid high with new data (full throughput).
REQ-022 SHALL compute data_out = data_in ^ K, K per mode sampled at acceptance: 00 K=0; 01 K=bank[0]; 10 K=bank[idx]; 11 K=lfsr[DATA_W-1:0].
REQ-023 SHALL write bank[key_wr_addr] on key_wr_en; write visible from next cycle; same-cycle read of same entry SHALL use old value.
REQ-024 SHALL increment idx on each acceptance in mode 10, wrapping KEY_DEPTH-1 -> 0; idx held in other modes.
REQ-025 SHALL use 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1: next = {s[0]^s[2]^s[3]^s[5], s[15:1]}, stepped once per acceptance in mode 11 only.
REQ-026 SHALL, when restart is high, make any beat accepted that cycle use idx=0 and lfsr=seed, then set idx = (accepted && mode==10) ? 1 : 0 and lfsr = (accepted && mode==11) ? step(seed) : seed.
REQ-027 SHALL substitute seed 16'hACE1 whenever lfsr_seed is 0 (no lock-up).
REQ-028 SHALL apply mode changes from the next accepted beat; idx and lfsr retain values across mode changes.

Reset
REQ-029 SHALL on rst: out_valid=0, data_out=0, idx=0, lfsr=16'hACE1, all bank entries 0; rst SHALL override restart, key writes and acceptance that cycle.
REQ-030 SHALL drop an in-flight output beat when rst is asserted mid-operation; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-031 SHALL cover static mode: DATA_W=8, bank[0]=0F, data AA,55,F0 back-to-back, out_ready=1 -> data_out A5,5A,FF, one cycle latency each, no bubbles.
REQ-032 SHALL cover rotation and wrap: bank={01,02,04,08}, mode 10, five beats of 00 -> 01,02,04,08,01.
REQ-033 SHALL cover restart mid-stream: mode 10 after three beats, restart with fourth beat -> fourth output 01, fifth 02.
REQ-034 SHALL cover backpressure: out_ready=0, two beats offered -> first held on data_out, in_ready=0, second beat held upstream; out_ready=1 -> both delivered in order unchanged.
REQ-035 SHALL cover LFSR: seed 0001, restart, mode 11, data 00,00 -> 01,00; seed 0000 -> first output E1.
REQ-036 SHALL cover reset mid-operation: rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, data_out=00, bank reads 00, in_ready=1 after release.
